// File: rtl/irq_sched_pkg.sv
// Shared definitions for the interrupt priority scheduler.
//   - APB register word addresses (only paddr[3:0] is decoded)
//   - MODE register encodings
//   - Grant FSM state type
package irq_sched_pkg;

  localparam logic [3:0] ADDR_MASK    = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h1;
  localparam logic [3:0] ADDR_MODE    = 4'h2;
  localparam logic [3:0] ADDR_STATUS  = 4'h3;
  localparam logic [3:0] ADDR_SWSET   = 4'h9;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/irq_rr_picker.sv
// Combinational rotating priority encoder.
// Searches the eligible vector upward starting at index `start`, wrapping
// from NUM_IRQ-1 back to 0, and reports the first set bit.
// Ports:
//   eligible [NUM_IRQ] : candidate sources
//   start    [ID_W]    : index searched first (0 gives fixed priority)
//   found              : 1 when any eligible bit is set
//   id       [ID_W]    : index of the winner (0 when nothing found)
module irq_rr_picker #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]    start,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  function automatic int rot_idx(input logic [ID_W-1:0] s, input int off);
    return (int'(s) + off) % NUM_IRQ;
  endfunction

  // Walk offsets from farthest to nearest so the nearest match is the
  // last assignment and therefore wins.
  always_comb begin
    found = 1'b0;
    id    = '0;
    for (int off = NUM_IRQ - 1; off >= 0; off--) begin
      if (eligible[rot_idx(start, off)]) begin
        found = 1'b1;
        id    = ID_W'(rot_idx(start, off));
      end
    end
  end

endmodule

// File: rtl/irq_priority_scheduler.sv
// Interrupt sequencing core: pending latch, mask filter, fixed or
// round-robin selection and a request/acknowledge handshake to the CPU,
// configured through a zero-wait-state APB slave on pclk_i.
// Ports:
//   pclk_i, rst_i                 : clock, synchronous active-high reset
//   psel_i, penable_i, pwrite_i   : APB control
//   paddr_i, pwdata_i, prdata_o   : APB address / data (addr[3:0] decoded)
//   pready_o                      : tied high
//   irq_trigger_i [NUM_IRQ]       : event pulses, sampled every edge
//   irq_o, irq_id_o               : request and granted source index
//   irq_ack_i                     : CPU acknowledge of the current grant
module irq_priority_scheduler
  import irq_sched_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  input  logic [NUM_IRQ-1:0] irq_trigger_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               irq_ack_i
);

  logic [3:0]         addr;
  logic               wr_en;
  logic               rd_en;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] swset;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               mode;
  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    start;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic               ack_fire;
  logic               unused_bits;

  assign addr     = paddr_i[3:0];
  assign wr_en    = psel_i & penable_i & pwrite_i;
  assign rd_en    = psel_i & penable_i & ~pwrite_i;
  assign pready_o = 1'b1;

  // Upper address and data bits carry no meaning for this block.
  assign unused_bits = ^{paddr_i[31:4], pwdata_i[31:NUM_IRQ]};

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_IRQ - 1) return '0;
    return id + 1'b1;
  endfunction

  assign ack_fire = (state == GRANT) && irq_ack_i;
  assign w1c      = (wr_en && addr == ADDR_PENDING) ? pwdata_i[NUM_IRQ-1:0] : '0;
  assign swset    = (wr_en && addr == ADDR_SWSET)   ? pwdata_i[NUM_IRQ-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[irq_id_o] = 1'b1;
  end

  // Sets are OR-ed in after the clear so a trigger or SWSET on the same
  // edge as W1C / ack keeps the bit pending.
  assign pending_next = (pending & ~(w1c | ack_clr)) | irq_trigger_i | swset;
  assign eligible     = pending & mask;
  assign start        = (mode == MODE_RR) ? rr_ptr : '0;

  irq_rr_picker #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_picker (
    .eligible (eligible),
    .start    (start),
    .found    (pick_found),
    .id       (pick_id)
  );

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      mask    <= '0;
      pending <= '0;
      mode    <= MODE_FIXED;
    end else begin
      pending <= pending_next;
      if (wr_en && addr == ADDR_MASK) mask <= pwdata_i[NUM_IRQ-1:0];
      if (wr_en && addr == ADDR_MODE) mode <= pwdata_i[0];
    end
  end

  // Grant FSM. Once in GRANT the request is held until ack regardless of
  // later mask / W1C / mode changes; GAP forces one low cycle between grants.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            irq_id_o <= pick_id;
            irq_o    <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (irq_ack_i) begin
            irq_o  <= 1'b0;
            rr_ptr <= next_ptr(irq_id_o);
            state  <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          irq_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    prdata_o = '0;
    if (rd_en) begin
      case (addr)
        ADDR_MASK:    prdata_o[NUM_IRQ-1:0] = mask;
        ADDR_PENDING: prdata_o[NUM_IRQ-1:0] = pending;
        ADDR_MODE:    prdata_o[0]           = mode;
        ADDR_STATUS: begin
          prdata_o[8]      = irq_o;
          prdata_o[ID_W-1:0] = irq_id_o;
        end
        default:      prdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_scheduler.sv
// Directed bench for irq_priority_scheduler (NUM_IRQ = 4).
module tb_irq_priority_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic [3:0]  trig = '0;
  logic        irq;
  logic [1:0]  irq_id;
  logic        ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_priority_scheduler #(.NUM_IRQ(4)) dut (
    .pclk_i        (clk),
    .rst_i         (rst),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .paddr_i       (paddr),
    .pwdata_i      (pwdata),
    .prdata_o      (prdata),
    .pready_o      (pready),
    .irq_trigger_i (trig),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .irq_ack_i     (ack)
  );

  typedef struct {
    logic [3:0] mask;
    logic [3:0] pend;
    logic       exp_irq;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[7];

  // Advance across exactly one rising edge, ending on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {28'h0, a}; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {28'h0, a};
    tick();
    penable = 1'b1;
    #1 d = prdata;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    for (int i = 0; i < 20 && irq !== 1'b1; i++) tick();
    check(name, {31'h0, irq}, 32'h1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr_exp[5];

  initial begin
    vecs[0] = '{mask: 4'hF, pend: 4'b1010, exp_irq: 1'b1, exp_id: 2'd1};
    vecs[1] = '{mask: 4'hF, pend: 4'b1000, exp_irq: 1'b1, exp_id: 2'd3};
    vecs[2] = '{mask: 4'h0, pend: 4'b1111, exp_irq: 1'b0, exp_id: 2'd0};
    vecs[3] = '{mask: 4'hC, pend: 4'b1111, exp_irq: 1'b1, exp_id: 2'd2};
    vecs[4] = '{mask: 4'h8, pend: 4'b1001, exp_irq: 1'b1, exp_id: 2'd3};
    vecs[5] = '{mask: 4'hF, pend: 4'b0001, exp_irq: 1'b1, exp_id: 2'd0};
    vecs[6] = '{mask: 4'h6, pend: 4'b1001, exp_irq: 1'b0, exp_id: 2'd0};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    tick();
    do_reset();

    // Reset state
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_id", {30'h0, irq_id}, 32'h0);
    check("rst_pready", {31'h0, pready}, 32'h1);
    check("rst_prdata_idle", prdata, 32'h0);
    apb_read(4'h0, rd); check("rst_mask", rd, 32'h0);
    apb_read(4'h1, rd); check("rst_pending", rd, 32'h0);
    apb_read(4'h2, rd); check("rst_mode", rd, 32'h0);
    apb_read(4'h3, rd); check("rst_status", rd, 32'h0);
    apb_read(4'h5, rd); check("unmapped_read", rd, 32'h0);

    // Basic latency: trigger at edge N -> irq after N+1
    apb_write(4'h0, 32'h4);
    trig = 4'b0100;
    tick();
    trig = 4'b0000;
    check("basic_irq_after_1", {31'h0, irq}, 32'h0);
    tick();
    check("basic_irq_after_2", {31'h0, irq}, 32'h1);
    check("basic_id", {30'h0, irq_id}, 32'h2);
    do_ack();
    check("basic_irq_after_ack", {31'h0, irq}, 32'h0);
    apb_read(4'h1, rd); check("basic_pending_cleared", rd, 32'h0);

    // Fixed-priority selection table
    for (int v = 0; v < 7; v++) begin
      do_reset();
      apb_write(4'h0, {28'h0, vecs[v].mask});
      apb_write(4'h9, {28'h0, vecs[v].pend});
      tick();
      check($sformatf("vec%0d_irq", v), {31'h0, irq}, {31'h0, vecs[v].exp_irq});
      check($sformatf("vec%0d_id", v), {30'h0, irq_id}, {30'h0, vecs[v].exp_id});
    end

    // Fixed priority sequence 1 then 3 with GAP in between
    do_reset();
    apb_write(4'h0, 32'hF);
    trig = 4'b1010;
    tick();
    trig = 4'b0000;
    tick();
    check("fix_first_irq", {31'h0, irq}, 32'h1);
    check("fix_first_id", {30'h0, irq_id}, 32'h1);
    do_ack();
    check("fix_gap_low0", {31'h0, irq}, 32'h0);
    tick();
    check("fix_gap_low1", {31'h0, irq}, 32'h0);
    tick();
    check("fix_second_irq", {31'h0, irq}, 32'h1);
    check("fix_second_id", {30'h0, irq_id}, 32'h3);
    do_ack();
    tick(); tick(); tick();
    check("fix_idle_after", {31'h0, irq}, 32'h0);

    // Round robin with all sources kept pending
    do_reset();
    apb_write(4'h2, 32'h1);
    apb_write(4'h0, 32'hF);
    apb_write(4'h9, 32'hF);
    for (int k = 0; k < 5; k++) begin
      wait_irq($sformatf("rr%0d_irq", k));
      check($sformatf("rr%0d_id", k), {30'h0, irq_id}, {30'h0, rr_exp[k]});
      do_ack();
      apb_write(4'h9, 32'hF);
    end

    // Masked source, then unmask
    do_reset();
    apb_write(4'h0, 32'h1);
    trig = 4'b0010;
    tick();
    trig = 4'b0000;
    tick(); tick();
    check("mask_no_irq", {31'h0, irq}, 32'h0);
    apb_read(4'h1, rd); check("mask_pending", rd, 32'h2);
    apb_write(4'h0, 32'h3);
    check("unmask_not_yet", {31'h0, irq}, 32'h0);
    tick();
    check("unmask_irq", {31'h0, irq}, 32'h1);
    check("unmask_id", {30'h0, irq_id}, 32'h1);
    do_ack();
    apb_write(4'h0, 32'h1);
    trig = 4'b0010;
    tick();
    trig = 4'b0000;
    apb_write(4'h1, 32'h2);
    apb_read(4'h1, rd); check("w1c_pending", rd, 32'h0);
    check("w1c_no_irq", {31'h0, irq}, 32'h0);

    // Collision: trigger on the ack edge of the same source
    do_reset();
    apb_write(4'h0, 32'h4);
    trig = 4'b0100;
    tick();
    trig = 4'b0000;
    tick();
    check("coll_first_id", {30'h0, irq_id}, 32'h2);
    ack = 1'b1; trig = 4'b0100;
    tick();
    ack = 1'b0; trig = 4'b0000;
    check("coll_irq_low", {31'h0, irq}, 32'h0);
    apb_read(4'h1, rd); check("coll_pending_kept", rd, 32'h4);
    check("coll_regrant_irq", {31'h0, irq}, 32'h1);
    check("coll_regrant_id", {30'h0, irq_id}, 32'h2);
    do_ack();
    // W1C and trigger on the same bit in the same edge
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1; pwdata = 32'h2;
    tick();
    penable = 1'b1; trig = 4'b0010;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; trig = 4'b0000;
    apb_read(4'h1, rd); check("w1c_vs_set", rd, 32'h2);

    // Reset while id 3 is outstanding
    do_reset();
    apb_write(4'h0, 32'h8);
    trig = 4'b1000;
    tick();
    trig = 4'b0000;
    tick();
    check("rg_irq", {31'h0, irq}, 32'h1);
    apb_read(4'h3, rd); check("rg_status", rd, 32'h103);
    do_reset();
    check("rg_irq_dropped", {31'h0, irq}, 32'h0);
    check("rg_id_zero", {30'h0, irq_id}, 32'h0);
    apb_read(4'h1, rd); check("rg_pending", rd, 32'h0);
    apb_read(4'h0, rd); check("rg_mask", rd, 32'h0);
    tick(); tick(); tick();
    check("rg_no_regrant", {31'h0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
